// File: rtl/pixel_reorder_stream_if.sv
// Pixel input bus from the compute array plus the raster-order output stream.
// slave is the reorder block's view; master is the surrounding system's view.
interface pixel_reorder_stream_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RBG_SIZE   = 24
);
   logic                  px_valid_i;
   logic [DATA_WIDTH-1:0] xpixel_i;
   logic [DATA_WIDTH-1:0] ypixel_i;
   logic                  frame_i;
   logic [RBG_SIZE-1:0]   colour_i;
   logic                  full_queue;
   logic                  ready;
   logic [RBG_SIZE-1:0]   colour_o;
   logic                  valid;
   logic                  first;
   logic                  last_x;
   logic                  last_y;

   modport slave (
      input  px_valid_i, xpixel_i, ypixel_i, frame_i, colour_i, ready,
      output full_queue, colour_o, valid, first, last_x, last_y
   );

   modport master (
      output px_valid_i, xpixel_i, ypixel_i, frame_i, colour_i, ready,
      input  full_queue, colour_o, valid, first, last_x, last_y
   );
endinterface

// File: rtl/pixel_reorder_stream.sv
// Reorder window: accepts out-of-order pixel colours keyed by (x, y, frame parity)
// and re-emits them in strict raster order with valid/ready backpressure.
module pixel_reorder_stream #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RBG_SIZE   = 24,
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480,
   parameter int unsigned WIN_DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   pixel_reorder_stream_if.slave   px,
   output logic                    frame_done,
   output logic                    drop_err
);
   localparam int unsigned NumPix = IMG_W * IMG_H;
   localparam int unsigned LinW   = $clog2(NumPix);
   localparam int unsigned PtrW   = $clog2(WIN_DEPTH);
   localparam int unsigned XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [WIN_DEPTH-1:0] occ_q;
   logic [RBG_SIZE-1:0]  col_q [WIN_DEPTH];
   logic [PtrW-1:0]      head_ptr_q;
   logic [XW-1:0]        head_x_q;
   logic [YW-1:0]        head_y_q;
   logic [LinW-1:0]      head_lin_q;
   logic                 parity_q;
   logic                 frame_done_q;
   logic                 drop_err_q;

   logic            in_range, late, far, hit_head;
   logic            head_valid, xfer, at_last_x, last_pix;
   logic            accept, stall, drop;
   logic [LinW:0]   lin, off;
   logic [PtrW-1:0] wr_idx;

   assign in_range = (px.xpixel_i < DATA_WIDTH'(IMG_W)) && (px.ypixel_i < DATA_WIDTH'(IMG_H));
   assign lin      = (LinW+1)'(px.ypixel_i) * (LinW+1)'(IMG_W) + (LinW+1)'(px.xpixel_i);
   assign off      = lin - {1'b0, head_lin_q};
   assign late     = lin < {1'b0, head_lin_q};
   assign far      = off >= (LinW+1)'(WIN_DEPTH);
   assign wr_idx   = head_ptr_q + off[PtrW-1:0];

   assign head_valid = occ_q[head_ptr_q];
   assign xfer       = head_valid && px.ready;
   assign at_last_x  = head_x_q == XW'(IMG_W - 1);
   assign last_pix   = at_last_x && (head_y_q == YW'(IMG_H - 1));
   // The head pixel is already leaving, so a same-cycle write to it counts as late.
   assign hit_head   = (off == '0) && xfer;

   always_comb begin
      accept = 1'b0;
      stall  = 1'b0;
      drop   = 1'b0;
      if (px.px_valid_i && !reset) begin
         if (!in_range) begin
            drop = 1'b1;
         end else if (px.frame_i != parity_q) begin
            stall = 1'b1;
         end else if (late || hit_head) begin
            drop = 1'b1;
         end else if (far) begin
            stall = 1'b1;
         end else begin
            accept = 1'b1;
         end
      end
   end

   assign px.full_queue = stall;
   assign px.valid      = head_valid;
   assign px.colour_o   = head_valid ? col_q[head_ptr_q] : '0;
   assign px.first      = head_valid && (head_x_q == '0) && (head_y_q == '0);
   assign px.last_x     = head_valid && at_last_x;
   assign px.last_y     = head_valid && last_pix;
   assign frame_done    = frame_done_q;
   assign drop_err      = drop_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q        <= '0;
         head_ptr_q   <= '0;
         head_x_q     <= '0;
         head_y_q     <= '0;
         head_lin_q   <= '0;
         parity_q     <= 1'b0;
         frame_done_q <= 1'b0;
         drop_err_q   <= 1'b0;
      end else begin
         frame_done_q <= xfer && last_pix;
         drop_err_q   <= drop;
         if (xfer) begin
            occ_q[head_ptr_q] <= 1'b0;
            head_ptr_q        <= head_ptr_q + PtrW'(1);
            if (last_pix) begin
               head_x_q   <= '0;
               head_y_q   <= '0;
               head_lin_q <= '0;
               parity_q   <= ~parity_q;
            end else begin
               head_lin_q <= head_lin_q + LinW'(1);
               if (at_last_x) begin
                  head_x_q <= '0;
                  head_y_q <= head_y_q + YW'(1);
               end else begin
                  head_x_q <= head_x_q + XW'(1);
               end
            end
         end
         // An accepted write never targets the head slot while it transfers.
         if (accept) begin
            occ_q[wr_idx] <= 1'b1;
         end
      end
   end

   // Colour storage needs no reset: it is only visible through an occupied slot.
   always_ff @(posedge clk) begin
      if (accept) begin
         col_q[wr_idx] <= px.colour_i;
      end
   end
endmodule

// File: tb/tb_pixel_reorder_stream.sv
// Bench for pixel_reorder_stream at IMG_W=4, IMG_H=2, WIN_DEPTH=4: vector tables,
// hand-written corner sequences and a raster-order scoreboard on the output stream.
module tb_pixel_reorder_stream;
   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;
   localparam int unsigned WD = 4;

   typedef struct {
      int          x;
      int          y;
      bit          f;
      logic [23:0] c;
      bit          exp_full;
      bit          exp_drop;
      bit          chk_valid;
      bit          exp_valid;
      bit          push;
   } vec_t;

   typedef struct {
      logic [23:0] c;
      bit          first;
      bit          lx;
      bit          ly;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic frame_done, drop_err;

   pixel_reorder_stream_if #(.DATA_WIDTH(32), .RBG_SIZE(24)) bus ();

   pixel_reorder_stream #(
      .DATA_WIDTH(32), .RBG_SIZE(24), .IMG_W(W), .IMG_H(H), .WIN_DEPTH(WD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .px         (bus),
      .frame_done (frame_done),
      .drop_err   (drop_err)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   bit   cur_drop  = 1'b0;
   bit   drop_pipe = 1'b0;
   bit   fd_pipe   = 1'b0;
   bit   rdy_cfg   = 1'b0;
   vec_t tv1 [8];
   vec_t tv2 [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int x, input int y, input logic [23:0] c);
      exp_t e;
      e.c     = c;
      e.first = (x == 0) && (y == 0);
      e.lx    = (x == W - 1);
      e.ly    = (x == W - 1) && (y == H - 1);
      return e;
   endfunction

   function automatic vec_t mv(input int x, input int y, input bit f, input logic [23:0] c,
                               input bit ef, input bit ed, input bit cv, input bit ev,
                               input bit p);
      vec_t v;
      v.x = x; v.y = y; v.f = f; v.c = c;
      v.exp_full = ef; v.exp_drop = ed; v.chk_valid = cv; v.exp_valid = ev; v.push = p;
      return v;
   endfunction

   // Output monitor: scoreboard pops on handshake, plus one-cycle-late pulse checks.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         check("drop_err", drop_err, drop_pipe);
         check("frame_done", frame_done, fd_pipe);
         drop_pipe = bus.px_valid_i && cur_drop && !reset;
         fd_pipe   = 1'b0;
         if (!reset && bus.valid && bus.ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = sb.pop_front();
               check("colour_o", bus.colour_o, e.c);
               check("first", bus.first, e.first);
               check("last_x", bus.last_x, e.lx);
               check("last_y", bus.last_y, e.ly);
               fd_pipe = e.ly;
            end
         end
      end
   end

   task automatic drive(input int x, input int y, input bit f, input logic [23:0] c,
                        input bit d);
      @(posedge clk);
      #1;
      bus.px_valid_i = 1'b1;
      bus.xpixel_i   = 32'(x);
      bus.ypixel_i   = 32'(y);
      bus.frame_i    = f;
      bus.colour_i   = c;
      bus.ready      = rdy_cfg;
      cur_drop       = d;
      @(negedge clk);
   endtask

   task automatic present(input int x, input int y, input bit f, input logic [23:0] c,
                          input bit ef, input bit ed, input string nm);
      drive(x, y, f, c, ed);
      check({nm, "_full_queue"}, bus.full_queue, ef);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.px_valid_i = 1'b0;
         bus.ready      = rdy_cfg;
         cur_drop       = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      present(v.x, v.y, v.f, v.c, v.exp_full, v.exp_drop, nm);
      if (v.chk_valid) check({nm, "_valid"}, bus.valid, v.exp_valid);
      if (v.push) sb.push_back(mk(v.x, v.y, v.c));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      bit accepted;

      // In-order frame 0, colours 1..8.
      for (int i = 0; i < 8; i++) begin
         tv1[i] = mv(i % W, i / W, 1'b0, 24'(i + 1), 0, 0, 1, (i != 0), 1);
      end
      // Frame 1: reordered first line, then (0,1) stalls once on the window edge.
      tv2[0] = mv(2, 0, 1'b1, 24'hC0, 0, 0, 1, 0, 0);
      tv2[1] = mv(1, 0, 1'b1, 24'hB0, 0, 0, 1, 0, 0);
      tv2[2] = mv(3, 0, 1'b1, 24'hD0, 0, 0, 1, 0, 0);
      tv2[3] = mv(0, 0, 1'b1, 24'hA0, 0, 0, 1, 0, 0);
      tv2[4] = mv(0, 1, 1'b1, 24'h15, 1, 0, 1, 1, 0);
      tv2[5] = mv(0, 1, 1'b1, 24'h15, 0, 0, 1, 1, 1);
      tv2[6] = mv(1, 1, 1'b1, 24'h16, 0, 0, 1, 1, 1);
      tv2[7] = mv(2, 1, 1'b1, 24'h17, 0, 0, 1, 1, 1);
      tv2[8] = mv(3, 1, 1'b1, 24'h18, 0, 0, 1, 1, 1);

      reset          = 1'b1;
      bus.px_valid_i = 1'b0;
      bus.xpixel_i   = '0;
      bus.ypixel_i   = '0;
      bus.frame_i    = 1'b0;
      bus.colour_i   = '0;
      bus.ready      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bus.valid, 0);
      check("rst_colour", bus.colour_o, 0);
      check("rst_first", bus.first, 0);
      check("rst_last_x", bus.last_x, 0);
      check("rst_last_y", bus.last_y, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      rdy_cfg = 1'b1;
      for (int i = 0; i < 8; i++) run_vec(tv1[i], "inorder");
      idle(4);

      sb.push_back(mk(0, 0, 24'hA0));
      sb.push_back(mk(1, 0, 24'hB0));
      sb.push_back(mk(2, 0, 24'hC0));
      sb.push_back(mk(3, 0, 24'hD0));
      for (int i = 0; i < 9; i++) run_vec(tv2[i], "reorder");
      idle(5);

      // Frame 0 again, head at 0 and empty: (0,1) is one beyond the window.
      present(0, 1, 1'b0, 24'h21, 1, 0, "win_stall");
      check("win_stall_valid", bus.valid, 0);
      present(0, 1, 1'b0, 24'h21, 1, 0, "win_stall");
      present(0, 0, 1'b0, 24'h20, 0, 0, "win_head");
      sb.push_back(mk(0, 0, 24'h20));
      present(0, 1, 1'b0, 24'h21, 1, 0, "win_xfer");
      present(0, 1, 1'b0, 24'h21, 0, 0, "win_accept");

      present(0, 0, 1'b0, 24'h99, 0, 1, "late_drop");
      present(5, 0, 1'b0, 24'h99, 0, 1, "range_drop");
      idle(1);
      check("drop_valid", bus.valid, 0);

      rdy_cfg = 1'b0;
      present(1, 0, 1'b0, 24'h31, 0, 0, "bp_load");
      for (int i = 0; i < 5; i++) begin
         present(0, 0, 1'b1, 24'h40, 1, 0, "parity");
         check("bp_valid", bus.valid, 1);
         check("bp_colour", bus.colour_o, 24'h31);
         check("bp_first", bus.first, 0);
         check("bp_last_x", bus.last_x, 0);
         check("bp_last_y", bus.last_y, 0);
      end
      rdy_cfg = 1'b1;
      sb.push_back(mk(1, 0, 24'h31));
      present(2, 0, 1'b0, 24'h32, 0, 0, "fill");
      sb.push_back(mk(2, 0, 24'h32));
      present(3, 0, 1'b0, 24'h33, 0, 0, "fill");
      sb.push_back(mk(3, 0, 24'h33));
      sb.push_back(mk(0, 1, 24'h21));
      present(1, 1, 1'b0, 24'h35, 0, 0, "fill");
      sb.push_back(mk(1, 1, 24'h35));
      present(2, 1, 1'b0, 24'h36, 0, 0, "fill");
      sb.push_back(mk(2, 1, 24'h36));
      present(3, 1, 1'b0, 24'h37, 0, 0, "fill");
      sb.push_back(mk(3, 1, 24'h37));

      // Next-frame pixel waits for the last two frame-0 pixels to leave.
      stalls   = 0;
      accepted = 1'b0;
      for (int i = 0; i < 10 && !accepted; i++) begin
         drive(0, 0, 1'b1, 24'h40, 1'b0);
         if (bus.full_queue) stalls++;
         else accepted = 1'b1;
      end
      check("parity_accepted", accepted, 1);
      check("parity_stall_cycles", stalls, 2);
      sb.push_back(mk(0, 0, 24'h40));

      present(1, 0, 1'b1, 24'h41, 0, 0, "pre_rst");
      sb.push_back(mk(1, 0, 24'h41));
      present(2, 0, 1'b1, 24'h42, 0, 0, "pre_rst");
      sb.push_back(mk(2, 0, 24'h42));
      idle(2);
      rdy_cfg = 1'b0;
      present(3, 0, 1'b1, 24'h43, 0, 0, "pre_rst");
      idle(1);
      check("pre_rst_valid", bus.valid, 1);

      // Mid-frame reset while a frame-0 pixel (parity mismatch) is presented.
      @(posedge clk);
      #1;
      reset          = 1'b1;
      bus.px_valid_i = 1'b1;
      bus.xpixel_i   = 32'd0;
      bus.ypixel_i   = 32'd0;
      bus.frame_i    = 1'b0;
      bus.colour_i   = 24'h77;
      bus.ready      = 1'b0;
      cur_drop       = 1'b0;
      @(negedge clk);
      check("rst_full_queue", bus.full_queue, 0);
      @(posedge clk);
      #1;
      reset          = 1'b0;
      bus.px_valid_i = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", bus.valid, 0);
      check("mid_rst_colour", bus.colour_o, 0);
      check("mid_rst_first", bus.first, 0);
      check("mid_rst_last_x", bus.last_x, 0);
      check("mid_rst_last_y", bus.last_y, 0);

      rdy_cfg = 1'b1;
      present(0, 0, 1'b0, 24'h55, 0, 0, "post_rst");
      sb.push_back(mk(0, 0, 24'h55));
      idle(3);
      check("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pixel_reorder_stream.md
Name: pixel_reorder_stream

Overview:
- Parametrised successor to the pixel queue/combinator pair.
- Accepts colour results from pixel compute engines in any order within a bounded window, keyed by (x, y) and frame parity.
- Re-emits them strictly in raster order on the pixel-generator stream: colour_o, first, last_x, last_y, valid, with ready backpressure.
- Sits between the compute array and the video pixel generator.

Parameters:
- DATA_WIDTH, 32: width of xpixel_i and ypixel_i.
- RBG_SIZE, 24: colour width.
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame.
- WIN_DEPTH, 16: reorder window size in raster positions. Power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- px_valid_i  in  1  input pixel present.
- xpixel_i  in  DATA_WIDTH  pixel x coordinate.
- ypixel_i  in  DATA_WIDTH  pixel y coordinate.
- frame_i  in  1  frame parity of the input pixel.
- colour_i  in  RBG_SIZE  pixel colour.
- full_queue  out  1  input stall; pixel not accepted this cycle, hold it.
- ready  in  1  downstream ready.
- colour_o  out  RBG_SIZE  colour of the head pixel.
- valid  out  1  head pixel available.
- first  out  1  head is (0,0).
- last_x  out  1  head x == IMG_W-1.
- last_y  out  1  head is the final pixel of the frame (IMG_W-1, IMG_H-1).
- frame_done  out  1  one-cycle pulse after the final pixel handshake.
- drop_err  out  1  one-cycle pulse: an input pixel was discarded.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- State:
  - circular slot array WIN_DEPTH × {occupied, colour}
  - head_ptr (log2 WIN_DEPTH bits)
  - head_x, head_y counters
  - head_lin = linear raster index, width clog2(IMG_W*IMG_H)
  - parity bit
- Reset (any time, including mid-frame): all slots cleared, head counters 0, parity 0. Outputs valid, colour_o, first, last_x, last_y, frame_done, drop_err are all 0 in the cycle after reset. full_queue is 0 while reset is high.
- Input classification (combinational, when px_valid_i=1):
  - lin = y*IMG_W + x
  - off = lin − head_lin
  - (a) x≥IMG_W or y≥IMG_H → drop.
  - (b) frame_i≠parity → stall: full_queue=1, no write.
  - (c) lin<head_lin → late, drop.
  - (d) off≥WIN_DEPTH → stall: full_queue=1.
  - (e) otherwise accept: write slot (head_ptr+off) mod WIN_DEPTH, set occupied. A write to an already-occupied slot overwrites colour; this is not an error.
- full_queue is 0 whenever px_valid_i=0. No input is consumed when full_queue=1.
- drop_err is registered: it pulses 1 cycle after the dropped input cycle.
- Output side:
  - valid = occupied[head_ptr]; colour_o = slot colour.
  - first, last_x, last_y are decoded from registered head_x and head_y.
  - All outputs are combinational from registers only; there is no input→output path.
- Latency: a pixel accepted into the head slot in cycle N gives valid=1 in cycle N+1.
- Handshake:
  - A transfer occurs when valid && ready.
  - On transfer: clear the head slot, head_ptr++, head_lin++, head_x++.
  - At head_x==IMG_W-1: head_x wraps to 0 and head_y++.
  - At the final pixel: head_x, head_y and head_lin wrap to 0, parity toggles, frame_done pulses next cycle.
  - valid=1 with ready=0 holds colour_o and all flags stable.
- Simultaneous accept and transfer:
  - Offset uses the pre-transfer head_lin.
  - A write with off=0 in the same cycle as a transfer is classified late (the pixel is already leaving) and dropped.
  - A write to any other slot proceeds normally.
- The window never spans a frame boundary. Next-frame pixels stall via parity until the wrap.
- Arithmetic: lin computed at clog2(IMG_W*IMG_H)+1 bits. Coordinates compared at full DATA_WIDTH before truncation.

Test Plan (IMG_W=4, IMG_H=2, WIN_DEPTH=4):
- In-order: feed (0,0)…(3,1), parity 0, colours 1..8, ready=1.
  - colour_o 1..8 on consecutive cycles.
  - first only with 1; last_x with 4 and 8; last_y only with 8.
  - frame_done pulses the cycle after 8.
- Reorder: feed (2,0)=C, (1,0)=B, (3,0)=D, (0,0)=A.
  - valid stays 0 until A is written.
  - Then A, B, C, D stream on 4 cycles.
- Window stall: head at 0, empty; present (0,1).
  - off=4, so full_queue=1 and nothing is stored.
  - After (0,0) transfers, (0,1) is accepted.
- Drops: after (0,0) transfers, send (0,0) again, then (5,0).
  - drop_err pulses once for each; no output change.
- Backpressure and parity: ready=0 with head valid; colour_o and flags stay stable for 5 cycles.
  - Also present a frame_i=1 pixel mid-frame: full_queue=1 until frame 0 completes, then accepted.
- Reset mid-frame: after 3 transfers, pulse reset.
  - Next cycle valid=0 and parity 0.
  - Re-feeding (0,0) gives first=1.
